// File: rtl/world_map_scheduler.sv
// Arbiter for the world-map RAM read port. Video tile fetches take priority;
// single-tile robot reads are served by a four-state handshake FSM.
module world_map_scheduler #(
    parameter int ADDR_W     = 14,
    parameter int TILE_SHIFT = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        pix_row,
    input  logic [9:0]        pix_col,
    input  logic              video_on,
    output logic [ADDR_W-1:0] map_addr,
    input  logic [1:0]        map_data,
    output logic [1:0]        world_pix,
    output logic              video_en_out,
    input  logic              bot_req,
    input  logic [ADDR_W-1:0] bot_addr,
    output logic              bot_ack,
    output logic [1:0]        bot_data
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} botState_t;

    botState_t         state;
    botState_t         stateNext;
    logic              vidSlot;
    logic [ADDR_W-1:0] vidAddr;
    logic              botGrant;
    logic              vidSlotD1;
    logic              vidSlotD2;
    logic              videoOnD1;
    logic              videoOnD2;
    logic              botAckNext;
    logic [1:0]        botDataNext;
    logic              unusedRowBits;

    assign vidSlot       = video_on && (pix_col[TILE_SHIFT-1:0] == '0);
    assign vidAddr       = ADDR_W'({pix_row[9:TILE_SHIFT], pix_col[9:TILE_SHIFT]});
    assign botGrant      = !vidSlot && (state == IDLE) && bot_req;
    assign unusedRowBits = ^pix_row[TILE_SHIFT-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (botGrant) stateNext = ADDR;
            ADDR:    stateNext = DATA;
            DATA:    stateNext = ACK;
            ACK:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // The ack and result are computed here and registered below, so both
    // outputs come straight from flops.
    always_comb begin
        botAckNext  = 1'b0;
        botDataNext = bot_data;
        if (state == DATA) begin
            botAckNext  = 1'b1;
            botDataNext = map_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            map_addr <= '0;
        end else if (vidSlot) begin
            map_addr <= vidAddr;
        end else if (botGrant) begin
            map_addr <= bot_addr;
        end
    end

    // Two-stage slot marker: RAM data for a grant at t arrives during t+2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vidSlotD1    <= 1'b0;
            vidSlotD2    <= 1'b0;
            world_pix    <= '0;
            videoOnD1    <= 1'b0;
            videoOnD2    <= 1'b0;
            video_en_out <= 1'b0;
            bot_ack      <= 1'b0;
            bot_data     <= '0;
        end else begin
            vidSlotD1    <= vidSlot;
            vidSlotD2    <= vidSlotD1;
            if (vidSlotD2) begin
                world_pix <= map_data;
            end
            videoOnD1    <= video_on;
            videoOnD2    <= videoOnD1;
            video_en_out <= videoOnD2;
            bot_ack      <= botAckNext;
            bot_data     <= botDataNext;
        end
    end

endmodule

// File: tb/tb_world_map_scheduler.sv
// Bench for world_map_scheduler: address table, directed corner sequences,
// and a randomized streaming run against a cycle-history reference model.
module tb_world_map_scheduler;

    localparam int N = 3000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  pix_row;
    logic [9:0]  pix_col;
    logic        video_on;
    logic [13:0] map_addr;
    logic [1:0]  map_data;
    logic [1:0]  world_pix;
    logic        video_en_out;
    logic        bot_req;
    logic [13:0] bot_addr;
    logic        bot_ack;
    logic [1:0]  bot_data;

    int checks   = 0;
    int failures = 0;

    world_map_scheduler #(.ADDR_W(14), .TILE_SHIFT(3)) dut (
        .clk(clk), .reset_n(reset_n), .pix_row(pix_row), .pix_col(pix_col),
        .video_on(video_on), .map_addr(map_addr), .map_data(map_data),
        .world_pix(world_pix), .video_en_out(video_en_out), .bot_req(bot_req),
        .bot_addr(bot_addr), .bot_ack(bot_ack), .bot_data(bot_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  row;
        logic [9:0]  col;
        logic        von;
        logic [13:0] expAddr;
    } vec_t;

    vec_t tbl[7];

    bit         vonH[N];
    bit         slotH[N];
    logic [1:0] mdH[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        pix_row = '0; pix_col = 10'd1; video_on = 1'b0;
        map_data = '0; bot_req = 1'b0; bot_addr = '0;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        idleInputs();
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int g;
        int reqStart;
        logic [13:0] expAddr;
        logic [1:0]  expPix, expData;
        bit          expEn, expAck, slot;

        // Reset with random inputs
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pix_row = 10'($urandom); pix_col = 10'($urandom); video_on = 1'($urandom);
            map_data = 2'($urandom); bot_req = 1'($urandom); bot_addr = 14'($urandom);
            tick();
            chk("reset_outputs", {map_addr, world_pix, video_en_out, bot_ack, bot_data}, 0);
        end
        idleInputs();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_reset_outputs", {map_addr, world_pix, video_en_out, bot_ack, bot_data}, 0);
        end

        // Table: video address mapping and hold behaviour
        tbl[0] = '{10'd16,   10'd24,   1'b1, 14'h0103};
        tbl[1] = '{10'd8,    10'd8,    1'b1, 14'h0081};
        tbl[2] = '{10'd1023, 10'd1016, 1'b1, 14'h3FFF};
        tbl[3] = '{10'd479,  10'd639,  1'b1, 14'h3FFF};
        tbl[4] = '{10'd40,   10'd80,   1'b0, 14'h3FFF};
        tbl[5] = '{10'd0,    10'd0,    1'b1, 14'h0000};
        tbl[6] = '{10'd200,  10'd328,  1'b1, 14'h0CA9};
        for (int i = 0; i < 7; i++) begin
            pix_row = tbl[i].row; pix_col = tbl[i].col; video_on = tbl[i].von;
            tick();
            chk($sformatf("table_addr_%0d", i), map_addr, tbl[i].expAddr);
        end

        // Video fetch
        doReset();
        repeat (3) tick();
        pix_row = 10'd16; pix_col = 10'd24; video_on = 1'b1;
        tick();
        chk("vid_addr", map_addr, 14'h0103);
        chk("vid_en_t1", video_en_out, 0);
        pix_col = 10'd25;
        tick();
        pix_col = 10'd26; map_data = 2'b10;
        tick();
        chk("vid_pix_t3", world_pix, 2'b10);
        chk("vid_en_t3", video_en_out, 1);
        for (int c = 27; c <= 31; c++) begin
            pix_col = 10'(c); map_data = 2'b01;
            tick();
        end
        pix_col = 10'd32; map_data = 2'b11;
        tick();
        chk("vid_pix_held", world_pix, 2'b10);
        video_on = 1'b0; pix_col = 10'd33;
        repeat (2) tick();
        chk("vid_en_still_on", video_en_out, 1);
        tick();
        chk("vid_en_off", video_en_out, 0);

        // Bot read with video off
        doReset();
        bot_req = 1'b1; bot_addr = 14'h1234;
        tick();
        chk("bot_addr", map_addr, 14'h1234);
        chk("bot_ack_t1", bot_ack, 0);
        tick();
        map_data = 2'b11;
        tick();
        chk("bot_ack_t3", bot_ack, 1);
        chk("bot_data_t3", bot_data, 2'b11);
        bot_req = 1'b0; map_data = 2'b00;
        tick();
        chk("bot_ack_t4", bot_ack, 0);
        chk("bot_data_held", bot_data, 2'b11);

        // Collision with a video slot
        doReset();
        video_on = 1'b1; pix_row = 10'd16; pix_col = 10'd40;
        bot_req = 1'b1; bot_addr = 14'h1234;
        tick();
        chk("col_vid_addr", map_addr, 14'h0105);
        pix_col = 10'd41;
        tick();
        chk("col_bot_addr", map_addr, 14'h1234);
        pix_col = 10'd42; map_data = 2'b01;
        tick();
        chk("col_pix", world_pix, 2'b01);
        chk("col_ack_t3", bot_ack, 0);
        pix_col = 10'd43; map_data = 2'b10;
        tick();
        chk("col_ack_t4", bot_ack, 1);
        chk("col_bot_data", bot_data, 2'b10);
        chk("col_pix_kept", world_pix, 2'b01);
        bot_req = 1'b0; pix_col = 10'd44;
        tick();
        chk("col_ack_t5", bot_ack, 0);

        // Reset in the middle of a bot read
        doReset();
        bot_req = 1'b1; bot_addr = 14'h0ABC;
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_async", {map_addr, bot_ack, bot_data}, 0);
        repeat (3) tick();
        reset_n = 1'b1; bot_req = 1'b0;
        begin
            int acks = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (bot_ack) acks++;
            end
            chk("midrst_no_ack", acks, 0);
        end
        bot_req = 1'b1; bot_addr = 14'h0055; map_data = 2'b01;
        tick();
        chk("midrst_new_addr", map_addr, 14'h0055);
        repeat (2) tick();
        chk("midrst_new_ack", bot_ack, 1);
        chk("midrst_new_data", bot_data, 2'b01);
        bot_req = 1'b0;
        tick();

        // Randomized streaming against the history model
        doReset();
        g = -100; reqStart = 0;
        expAddr = '0; expPix = '0; expData = '0;
        for (int t = 0; t < N; t++) begin
            pix_col  = 10'(t % 1024);
            pix_row  = 10'(37 + t / 1024);
            video_on = (pix_col < 10'd800) ^ ($urandom_range(0, 49) == 0);
            map_data = 2'($urandom);
            if (bot_ack) begin
                bot_req = 1'b0;
            end else if (!bot_req && (t % 5 == 0 || $urandom_range(0, 3) == 0)) begin
                bot_req  = 1'b1;
                bot_addr = 14'($urandom);
                reqStart = t;
            end

            slot = video_on && (pix_col % 8 == 0);
            vonH[t] = video_on; slotH[t] = slot; mdH[t] = map_data;
            if (slot) expAddr = {pix_row[9:3], pix_col[9:3]};
            else if (t >= g + 4 && bot_req) begin
                expAddr = bot_addr;
                g = t;
            end
            if (t >= 2 && slotH[t-2]) expPix = mdH[t];
            expEn  = (t >= 2) ? vonH[t-2] : 1'b0;
            expAck = (t + 1 == g + 3);
            if (t == g + 2) expData = mdH[t];

            tick();
            chk("rnd_map_addr", map_addr, expAddr);
            chk("rnd_world_pix", world_pix, expPix);
            chk("rnd_video_en", video_en_out, expEn);
            chk("rnd_bot_ack", bot_ack, expAck);
            chk("rnd_bot_data", bot_data, expData);
            if (bot_req && !bot_ack && (t + 1 - reqStart) >= 4) begin
                chk("rnd_ack_timeout", t + 1 - reqStart, 3);
                bot_req = 1'b0;
            end
            if (bot_ack && bot_req) begin
                chk("rnd_ack_latency_ok", (t + 1 - reqStart) <= 4, 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
